// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit registers, two combinational read
// ports, one synchronous write port, x0 hardwired to zero.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] rd_d,
    input  logic              reg_wr,
    output logic [DATA_W-1:0] rs1_d,
    output logic [DATA_W-1:0] rs2_d
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic              w_wr_en;

    assign w_wr_en = reg_wr && (rd != '0);

    // NOTE: this array is deliberately reset, so it maps to flops rather than
    // a RAM macro; the core relies on every register reading zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every
                // flop samples pre-edge values regardless of statement order.
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= rd_d;
        end
    end

    // Reads return stored contents only, so a same-cycle write is not bypassed.
    assign rs1_d = (rs1 == '0) ? '0 : r_regs[rs1];
    assign rs2_d = (rs2 == '0) ? '0 : r_regs[rs2];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, enable gating,
// x0 hardwiring, read-during-write and asynchronous reset.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd_d;
    logic        reg_wr;
    logic [31:0] rs1_d, rs2_d;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .rd_d   (rd_d),
        .reg_wr (reg_wr),
        .rs1_d  (rs1_d),
        .rs2_d  (rs2_d)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One-edge write, inputs changed at the falling edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rd     = a;
        rd_d   = d;
        reg_wr = 1'b1;
        @(posedge clk);
        #1 reg_wr = 1'b0;
    endtask

    task automatic read2(input logic [4:0] a1, input logic [4:0] a2);
        rs1 = a1;
        rs2 = a2;
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rs1    = '0;
        rs2    = '0;
        rd     = '0;
        rd_d   = '0;
        reg_wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        read2(5'd0, 5'd0);
        check("por_x0", rs1_d, 32'h0);
        read2(5'd5, 5'd31);
        check("por_x5", rs1_d, 32'h0);
        check("por_x31", rs2_d, 32'h0);

        // Load x5/x31 so the reset pulse has something to clear.
        write_reg(5'd5, 32'hCAFE0005);
        write_reg(5'd31, 32'hCAFE001F);
        read2(5'd5, 5'd31);
        check("pre_rst_x5", rs1_d, 32'hCAFE0005);
        check("pre_rst_x31", rs2_d, 32'hCAFE001F);

        // Reset pulse entirely between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        read2(5'd0, 5'd0);
        check("rst_in_x0_p1", rs1_d, 32'h0);
        check("rst_in_x0_p2", rs2_d, 32'h0);
        read2(5'd5, 5'd31);
        check("rst_in_x5", rs1_d, 32'h0);
        check("rst_in_x31", rs2_d, 32'h0);
        rst_n = 1'b1;
        read2(5'd0, 5'd0);
        check("rst_out_x0", rs1_d, 32'h0);
        read2(5'd5, 5'd31);
        check("rst_out_x5", rs1_d, 32'h0);
        check("rst_out_x31", rs2_d, 32'h0);

        // Basic write/read and second register on port 2.
        write_reg(5'd1, 32'h00000001);
        read2(5'd1, 5'd0);
        check("wr_x1", rs1_d, 32'h00000001);
        write_reg(5'd3, 32'h00000002);
        read2(5'd1, 5'd3);
        check("wr_x3_p2", rs2_d, 32'h00000002);
        check("x1_kept", rs1_d, 32'h00000001);

        // Write-enable gating.
        @(negedge clk);
        rd     = 5'd3;
        rd_d   = 32'hDEADBEEF;
        reg_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("wr_gated_x3", rs2_d, 32'h00000002);

        // x0 is never written.
        read2(5'd0, 5'd3);
        check("x0_before", rs1_d, 32'h0);
        @(negedge clk);
        rd     = 5'd0;
        rd_d   = 32'hFFFFFFFF;
        reg_wr = 1'b1;
        repeat (3) @(posedge clk);
        #1 reg_wr = 1'b0;
        read2(5'd0, 5'd0);
        check("x0_after_p1", rs1_d, 32'h0);
        check("x0_after_p2", rs2_d, 32'h0);
        read2(5'd1, 5'd3);
        check("x0wr_x1", rs1_d, 32'h00000001);
        check("x0wr_x3", rs2_d, 32'h00000002);

        // Same address on both ports.
        read2(5'd3, 5'd3);
        check("dual_p1", rs1_d, 32'h00000002);
        check("dual_p2", rs2_d, 32'h00000002);

        // Read-during-write: old contents until the edge, new after.
        @(negedge clk);
        rs1    = 5'd7;
        rd     = 5'd7;
        rd_d   = 32'h12345678;
        reg_wr = 1'b1;
        #1 check("rdw_before", rs1_d, 32'h0);
        @(posedge clk);
        #1 check("rdw_after", rs1_d, 32'h12345678);
        reg_wr = 1'b0;

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_x7", rs1_d, 32'h0);
        read2(5'd1, 5'd3);
        check("async_rst_x1", rs1_d, 32'h0);
        check("async_rst_x3", rs2_d, 32'h0);

        // A pending write across an edge while in reset is discarded.
        rd     = 5'd9;
        rd_d   = 32'h99999999;
        reg_wr = 1'b1;
        @(posedge clk);
        #1 reg_wr = 1'b0;
        rst_n = 1'b1;
        read2(5'd9, 5'd9);
        check("rst_blocks_wr", rs1_d, 32'h0);

        // Fill every register, then read all back on both ports.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'hA5000000 | 32'(i * 32'h00010101));
        end
        for (int i = 1; i < 32; i++) begin
            read2(5'(i), 5'(32 - i));
            check($sformatf("fill_p1_x%0d", i), rs1_d, 32'hA5000000 | 32'(i * 32'h00010101));
            check($sformatf("fill_p2_x%0d", 32 - i), rs2_d,
                  32'hA5000000 | 32'((32 - i) * 32'h00010101));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
